home_ctrl_fsm_param: RTL
========================

// Module: home_ctrl_fsm_param
// PURPOSE
//  Parametrised home-automation controller. Next generation of the fixed 4-sensor/6-bit-temp FSM.
//  Adds N prioritised sensor channels, per-channel debounce, a minimum alarm dwell time,
//  an acknowledge handshake, and temperature hysteresis for the cooler and heater.
//  Sits between the sensor/temperature front end and the actuator/display drivers.
// PARAMETERS
//  NUM_SENSORS  4   number of sensor channels; index 0 has the highest priority
//  TEMP_W       6   temperature width, unsigned
//  TEMP_HI      40  cooler on at temp >= TEMP_HI
//  TEMP_LO      15  heater on at temp <= TEMP_LO
//  TEMP_HYST    3   hysteresis; must satisfy TEMP_LO+TEMP_HYST < TEMP_HI-TEMP_HYST
//  DEBOUNCE     4   consecutive high samples needed to qualify a sensor (>=1)
//  HOLD_CYCLES  8   minimum cycles in ALARM before an ack is honoured (>=1)
// PORTS
//  clk             in   1              single clock, rising edge
//  rst             in   1              synchronous, active-high reset
//  sensors         in   NUM_SENSORS    raw sensor levels
//  temp            in   TEMP_W         temperature sample
//  ack             in   1              level; operator acknowledge
//  output_signals  out  NUM_SENSORS+2  [N-1:0] one-hot alarm, [N] cooler, [N+1] heater
//  display         out  3              state code
//  active_idx      out  $clog2(NUM_SENSORS)  channel currently in alarm
//  alarm_count     out  8              alarm event count (see CONFIGURATION)
// BEHAVIOUR
//  Reset:
//  - rst sampled at clk edge; takes priority over all other logic.
//  - State -> IDLE. All outputs = 0. Debounce and dwell counters = 0.
//  Debounce, per channel:
//  - Counter increments while sensor high, saturating at DEBOUNCE. Any low sample clears it.
//  - stable[i] is registered; it is 1 when the counter == DEBOUNCE.
//  States and display codes: IDLE=0, ALARM=1, COOL=3, HEAT=4. Codes 2, 5-7 are unused and recover to IDLE.
//  pend = any stable bit set. pidx = lowest set index.
//  IDLE:
//  - pend -> ALARM(pidx).
//  - else temp>=TEMP_HI -> COOL.
//  - else temp<=TEMP_LO -> HEAT.
//  COOL / HEAT:
//  - pend -> ALARM(pidx); this takes priority over temperature.
//  - COOL -> IDLE when temp <= TEMP_HI-TEMP_HYST.
//  - HEAT -> IDLE when temp >= TEMP_LO+TEMP_HYST.
//  ALARM(k), dwell counter:
//  - Cleared on entry; increments each cycle, saturating at HOLD_CYCLES.
//  ALARM(k), pre-emption:
//  - If pidx < k: switch to ALARM(pidx) and clear dwell. Pre-emption wins over a same-cycle ack.
//  ALARM(k), exit (requires dwell==HOLD_CYCLES && ack && !stable[k]):
//  - If pend: go to ALARM(pidx) and clear dwell.
//  - Else: go to IDLE.
//  ALARM(k), ack handling:
//  - ack before dwell expiry, or while stable[k]=1, is ignored and not latched.
//  - ack in any other state is ignored.
//  Outputs:
//  - Registered and Moore-style, updated on the same edge as the state.
//  - output_signals[k]=1 only in ALARM(k); bit N=1 only in COOL; bit N+1=1 only in HEAT.
//  - Exactly one output bit is high, or none.
//  - active_idx holds k in ALARM; it is 0 otherwise.
//  Latency:
//  - A sensor high from edge 1 qualifies at edge DEBOUNCE.
//  - ALARM becomes visible after edge DEBOUNCE+1.
//  - A temperature change is visible one edge after it is sampled.
//  Arithmetic:
//  - All compares are unsigned at TEMP_W bits.
//  - Thresholds are truncated to TEMP_W.
//  - Counters saturate and never wrap.
// CONFIGURATION
//  HOME_CTRL_ALARM_COUNT_EN defined:
//  - alarm_count increments on every entry into ALARM, including pre-emption and channel switch.
//  - Saturates at 255. Reset value is 0.
//  HOME_CTRL_ALARM_COUNT_EN undefined:
//  - alarm_count is tied to 8'd0 and no counter logic is built.
// TESTING (defaults; N=4, so output_signals is 6 bits)
//  T1: sensors=4'b0100 for 3 cycles, then 0 -> no change.
//      Held 4 cycles -> after edge 5: display=1, output_signals=6'b000100, active_idx=2.
//  T2: In ALARM(2), sensors=4'b0101 held 4 cycles -> output_signals=6'b000001, active_idx=0, dwell restarts.
//  T3: In ALARM(0), drop sensor0, ack=1 at dwell 5 -> stays in ALARM(0).
//      Ack held to dwell 8 -> next state ALARM(2), since sensor2 is still stable.
//      Clear all sensors + ack -> IDLE, output_signals=0.
//  T4: temp=40 -> COOL, 6'b010000; temp=38 -> stays; temp=37 -> IDLE.
//      temp=15 -> HEAT, 6'b100000; temp=17 -> stays; temp=18 -> IDLE.
//  T5: In COOL, sensors=4'b1000 for 4 cycles -> ALARM(3), 6'b001000; the cooler bit drops on the same edge.
//  T6: rst=1 for one edge mid-ALARM, sensors held -> all outputs 0 and display=0 after that edge.
//      Re-alarm 5 edges after rst falls. With the macro: alarm_count = 0 after reset, then 1.

Source files
------------

// File: rtl/home_ctrl_fsm_param.sv
// home_ctrl_fsm_param
// Parametrised home-automation controller: N prioritised, debounced sensor
// channels raise alarms; temperature drives a cooler/heater with hysteresis.
// An alarm is held for at least HOLD_CYCLES and then needs an operator ack
// while its own sensor is no longer stable.
//
// Optional feature: define HOME_CTRL_ALARM_COUNT_EN to build a saturating
// 8-bit count of alarm entries on alarm_count; otherwise alarm_count is 0.
//
// Handshake: ack is a plain level, sampled every clock edge. It is only
// acted on in ALARM once the dwell has expired and the alarming sensor has
// dropped; at any other time it is ignored and never remembered.
//
// display carries the FSM state code and doubles as the state debug port.
module home_ctrl_fsm_param #(
   parameter int NUM_SENSORS = 4,
   parameter int TEMP_W      = 6,
   parameter int TEMP_HI     = 40,
   parameter int TEMP_LO     = 15,
   parameter int TEMP_HYST   = 3,
   parameter int DEBOUNCE    = 4,
   parameter int HOLD_CYCLES = 8,
   localparam int IDX_W      = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_SENSORS-1:0]   sensors,
   input  logic [TEMP_W-1:0]        temp,
   input  logic                     ack,
   output logic [NUM_SENSORS+1:0]   output_signals,
   output logic [2:0]               display,
   output logic [IDX_W-1:0]         active_idx,
   output logic [7:0]               alarm_count
);

   localparam int DB_W = $clog2(DEBOUNCE + 1);
   localparam int HD_W = $clog2(HOLD_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_MAX     = DB_W'(DEBOUNCE);
   localparam logic [HD_W-1:0]   HD_MAX     = HD_W'(HOLD_CYCLES);
   localparam logic [TEMP_W-1:0] T_HI       = TEMP_W'(TEMP_HI);
   localparam logic [TEMP_W-1:0] T_LO       = TEMP_W'(TEMP_LO);
   localparam logic [TEMP_W-1:0] T_COOL_OFF = TEMP_W'(TEMP_HI - TEMP_HYST);
   localparam logic [TEMP_W-1:0] T_HEAT_OFF = TEMP_W'(TEMP_LO + TEMP_HYST);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ALARM = 3'd1,
      S_COOL  = 3'd3,
      S_HEAT  = 3'd4
   } state_t;

   state_t                 state;
   state_t                 state_nx;
   logic [DB_W-1:0]        db_cnt [NUM_SENSORS];
   logic [NUM_SENSORS-1:0] stable;
   logic                   pend;
   logic [IDX_W-1:0]       pidx;
   logic [IDX_W-1:0]       idx_nx;
   logic                   alarm_entry;
   logic [HD_W-1:0]        dwell;
   logic [NUM_SENSORS+1:0] out_nx;

   assign display = state;

   // Per-channel debounce: saturating run-length of high samples; stable is
   // registered alongside the counter so it rises on the edge the count hits DEBOUNCE.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SENSORS; i++) db_cnt[i] <= '0;
         stable <= '0;
      end else begin
         for (int i = 0; i < NUM_SENSORS; i++) begin
            if (!sensors[i]) begin
               db_cnt[i] <= '0;
               stable[i] <= 1'b0;
            end else if (db_cnt[i] == DB_MAX) begin
               stable[i] <= 1'b1;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
               stable[i] <= (db_cnt[i] == DB_MAX - 1'b1);
            end
         end
      end
   end

   // Priority encoder: lowest stable channel index wins.
   always_comb begin
      pend = |stable;
      pidx = '0;
      for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
         if (stable[i]) pidx = IDX_W'(i);
      end
   end

   // Next-state logic; active_idx holds the alarming channel while in ALARM.
   always_comb begin
      state_nx    = state;
      idx_nx      = active_idx;
      alarm_entry = 1'b0;
      case (state)
         S_IDLE: begin
            if (pend) begin
               state_nx = S_ALARM; idx_nx = pidx; alarm_entry = 1'b1;
            end else if (temp >= T_HI) begin
               state_nx = S_COOL;
            end else if (temp <= T_LO) begin
               state_nx = S_HEAT;
            end
         end
         S_COOL: begin
            if (pend) begin
               state_nx = S_ALARM; idx_nx = pidx; alarm_entry = 1'b1;
            end else if (temp <= T_COOL_OFF) begin
               state_nx = S_IDLE;
            end
         end
         S_HEAT: begin
            if (pend) begin
               state_nx = S_ALARM; idx_nx = pidx; alarm_entry = 1'b1;
            end else if (temp >= T_HEAT_OFF) begin
               state_nx = S_IDLE;
            end
         end
         S_ALARM: begin
            // A higher-priority channel pre-empts, even against a same-cycle ack.
            if (pend && (pidx < active_idx)) begin
               idx_nx = pidx; alarm_entry = 1'b1;
            end else if ((dwell == HD_MAX) && ack && !stable[active_idx]) begin
               if (pend) begin
                  idx_nx = pidx; alarm_entry = 1'b1;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Moore output decode of the next state, registered with the state.
   always_comb begin
      out_nx = '0;
      case (state_nx)
         S_ALARM: out_nx[idx_nx]        = 1'b1;
         S_COOL:  out_nx[NUM_SENSORS]   = 1'b1;
         S_HEAT:  out_nx[NUM_SENSORS+1] = 1'b1;
         default: out_nx = '0;
      endcase
   end

   // Main FSM register: state, outputs, channel index and dwell counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         output_signals <= '0;
         active_idx     <= '0;
         dwell          <= '0;
      end else begin
         state          <= state_nx;
         output_signals <= out_nx;
         active_idx     <= (state_nx == S_ALARM) ? idx_nx : '0;
         if (alarm_entry || (state_nx != S_ALARM)) dwell <= '0;
         else if (dwell != HD_MAX)                 dwell <= dwell + 1'b1;
      end
   end

`ifdef HOME_CTRL_ALARM_COUNT_EN
   // Saturating count of every alarm entry, including channel switches.
   always_ff @(posedge clk) begin
      if (rst)                                  alarm_count <= 8'd0;
      else if (alarm_entry && alarm_count != 8'hFF) alarm_count <= alarm_count + 8'd1;
   end
`else
   assign alarm_count = 8'd0;
`endif

endmodule
